// File: rtl/mlu_pkg.sv
// mlu_pkg: shared types and constants for the MLU sequencer slice.
// Holds the command opcode and sequencer state enums, the lane count,
// and the MLU output-select / symbol encodings the datapath expects.
package mlu_pkg;

    localparam int LANES = 16;

    localparam logic [2:0] SEL_ACC    = 3'd2;
    localparam logic [2:0] SEL_NONLIN = 3'd4;
    localparam logic [2:0] SEL_KSORT  = 3'd5;

    localparam logic [1:0] SYM_SUB    = 2'b10;

    typedef enum logic [1:0] {
        OP_DOT    = 2'd0,
        OP_DIST   = 2'd1,
        OP_KNN    = 2'd2,
        OP_NONLIN = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_STREAM,
        ST_OUT,
        ST_RES,
        ST_CLR2,
        ST_KOUT
    } state_e;

    // DIST and KNN both feed the MLU through the subtract/square path.
    function automatic logic op_uses_sub(input op_e op);
        return (op == OP_DIST) || (op == OP_KNN);
    endfunction

endpackage

// File: rtl/mlu_loop_cnt.sv
// mlu_loop_cnt: loop counter with a loadable terminal value.
// Counts from zero up to the loaded limit, flags the last iteration and
// rearms to zero when stepped past it, so one load serves every pass of
// a command.
module mlu_loop_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;

    // Load restarts at zero with a new limit; an increment on the last value rearms to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (i_load) begin
            r_count <= '0;
            r_limit <= i_limit;
        end else if (i_inc) begin
            if (r_count == r_limit) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == r_limit);

endmodule

// File: rtl/mlu_seq.sv
// mlu_seq: command sequencer in front of the MLU datapath.
// Accepts one command, streams operand chunks into the MLU (zero-gated on
// non-beat cycles so the accumulator adds 0), pulses the clear/output
// controls and returns one scalar per vector, or one K-sorted list for KNN.
// Optional build macro MLU_SEQ_PERF_EN adds busy/stall performance counters.
module mlu_seq
    import mlu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int K           = 20,
    parameter int INDEX_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [LEN_WIDTH-1:0]        cmd_len,
    input  logic [LEN_WIDTH-1:0]        cmd_nvec,
    input  logic [2:0]                  cmd_fun_id,
    input  logic                        cmd_asce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_hot,
    input  logic [LANES*DATA_WIDTH-1:0] in_cold,
    output logic [LANES*DATA_WIDTH-1:0] mlu_hot,
    output logic [LANES*DATA_WIDTH-1:0] mlu_cold,
    output logic [1:0]                  mlu_symbol,
    output logic                        mlu_sel_in,
    output logic                        mlu_is_output,
    output logic                        mlu_clear_acc,
    output logic                        mlu_clear_sort,
    output logic [INDEX_WIDTH-1:0]      mlu_index,
    output logic [2:0]                  mlu_fun_id,
    output logic                        mlu_asce,
    output logic [2:0]                  mlu_sel_output,
    input  logic [31:0]                 mlu_out_scalar,
    input  logic [K*32-1:0]             mlu_out_ksort,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [31:0]                 res_data,
    output logic [K*32-1:0]             res_ksort,
    output logic                        res_last,
`ifdef MLU_SEQ_PERF_EN
    output logic [31:0]                 perf_busy_cycles,
    output logic [31:0]                 perf_stall_cycles,
`endif
    output logic                        busy
);

    state_e                 r_state;
    state_e                 w_state_next;
    op_e                    r_op;
    logic [2:0]             r_fun_id;
    logic                   r_asce;
    logic [31:0]            r_res_data;

    logic                   w_accept;
    logic                   w_beat;
    logic                   w_vec_inc;
    logic                   w_capture;
    logic [LEN_WIDTH-1:0]   w_len_last;
    logic [LEN_WIDTH-1:0]   w_nvec_last;
    logic [LEN_WIDTH-1:0]   w_chunk_cnt;
    logic                   w_chunk_last;
    logic [LEN_WIDTH-1:0]   w_vec_cnt;
    logic                   w_vec_last;
    logic                   w_unused_chunk;

    assign w_len_last  = (cmd_len  == '0) ? '0 : cmd_len  - LEN_WIDTH'(1);
    assign w_nvec_last = (cmd_nvec == '0) ? '0 : cmd_nvec - LEN_WIDTH'(1);

    mlu_loop_cnt #(.WIDTH(LEN_WIDTH)) u_chunk_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_limit (w_len_last),
        .i_inc   (w_beat),
        .o_count (w_chunk_cnt),
        .o_last  (w_chunk_last)
    );

    mlu_loop_cnt #(.WIDTH(LEN_WIDTH)) u_vec_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_limit (w_nvec_last),
        .i_inc   (w_vec_inc),
        .o_count (w_vec_cnt),
        .o_last  (w_vec_last)
    );

    assign w_unused_chunk = ^w_chunk_cnt;

    // State register; reset aborts any command straight back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshakes and MLU control pulses from the current state.
    always_comb begin
        w_state_next   = r_state;
        cmd_ready      = 1'b0;
        in_ready       = 1'b0;
        mlu_clear_acc  = 1'b0;
        mlu_clear_sort = 1'b0;
        mlu_is_output  = 1'b0;
        mlu_sel_output = 3'd0;
        res_valid      = 1'b0;
        res_last       = 1'b0;
        w_accept       = 1'b0;
        w_beat         = 1'b0;
        w_vec_inc      = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                mlu_clear_acc  = 1'b1;
                mlu_clear_sort = (r_op == OP_KNN);
                w_state_next   = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_beat = 1'b1;
                    if (w_chunk_last) begin
                        w_state_next = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                mlu_is_output  = 1'b1;
                mlu_sel_output = (r_op == OP_NONLIN) ? SEL_NONLIN : SEL_ACC;
                w_capture      = 1'b1;
                if (r_op == OP_KNN) begin
                    if (w_vec_last) begin
                        w_state_next = ST_KOUT;
                    end else begin
                        w_vec_inc    = 1'b1;
                        w_state_next = ST_CLR2;
                    end
                end else begin
                    w_state_next = ST_RES;
                end
            end
            ST_RES: begin
                res_valid = 1'b1;
                res_last  = w_vec_last;
                if (res_ready) begin
                    if (w_vec_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_vec_inc    = 1'b1;
                        w_state_next = ST_CLR2;
                    end
                end
            end
            ST_CLR2: begin
                mlu_clear_acc = 1'b1;
                w_state_next  = ST_STREAM;
            end
            ST_KOUT: begin
                mlu_sel_output = SEL_KSORT;
                res_valid      = 1'b1;
                res_last       = 1'b1;
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command fields are latched on accept; the scalar result is captured while the MLU presents it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_DOT;
            r_fun_id   <= 3'd0;
            r_asce     <= 1'b0;
            r_res_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op     <= op_e'(cmd_op);
                r_fun_id <= cmd_fun_id;
                r_asce   <= cmd_asce;
            end
            if (w_capture) begin
                r_res_data <= mlu_out_scalar;
            end
        end
    end

    assign mlu_hot    = w_beat ? in_hot  : '0;
    assign mlu_cold   = w_beat ? in_cold : '0;
    assign mlu_symbol = op_uses_sub(r_op) ? SYM_SUB : 2'b00;
    assign mlu_sel_in = op_uses_sub(r_op);
    assign mlu_index  = INDEX_WIDTH'(w_vec_cnt);
    assign mlu_fun_id = r_fun_id;
    assign mlu_asce   = r_asce;
    assign res_data   = r_res_data;
    assign res_ksort  = (r_state == ST_KOUT) ? mlu_out_ksort : '0;
    assign busy       = (r_state != ST_IDLE);

`ifdef MLU_SEQ_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = ((r_state == ST_STREAM) && !in_valid) ||
                     ((r_state == ST_RES) && !res_ready);

    // Saturating busy/stall counters, restarted by each accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else if (w_accept) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (busy && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mlu_seq.sv
// tb_mlu_seq: self-checking bench for the MLU sequencer.
// A small behavioural MLU (accumulator plus a shift-in result list) sits
// behind the DUT; expected results come from the operand data itself.
module tb_mlu_seq;
    import mlu_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int KK = 20;
    localparam int IW = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [LW-1:0]      cmd_len = '0;
    logic [LW-1:0]      cmd_nvec = '0;
    logic [2:0]         cmd_fun_id = 3'd0;
    logic               cmd_asce = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [16*DW-1:0]   in_hot = '0;
    logic [16*DW-1:0]   in_cold = '0;
    logic [16*DW-1:0]   mlu_hot;
    logic [16*DW-1:0]   mlu_cold;
    logic [1:0]         mlu_symbol;
    logic               mlu_sel_in;
    logic               mlu_is_output;
    logic               mlu_clear_acc;
    logic               mlu_clear_sort;
    logic [IW-1:0]      mlu_index;
    logic [2:0]         mlu_fun_id;
    logic               mlu_asce;
    logic [2:0]         mlu_sel_output;
    logic [31:0]        mlu_out_scalar;
    logic [KK*32-1:0]   mlu_out_ksort;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [31:0]        res_data;
    logic [KK*32-1:0]   res_ksort;
    logic               res_last;
    logic               busy;
`ifdef MLU_SEQ_PERF_EN
    logic [31:0]        perf_busy_cycles;
    logic [31:0]        perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mlu_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .K(KK), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_nvec(cmd_nvec), .cmd_fun_id(cmd_fun_id), .cmd_asce(cmd_asce),
        .in_valid(in_valid), .in_ready(in_ready), .in_hot(in_hot), .in_cold(in_cold),
        .mlu_hot(mlu_hot), .mlu_cold(mlu_cold), .mlu_symbol(mlu_symbol), .mlu_sel_in(mlu_sel_in),
        .mlu_is_output(mlu_is_output), .mlu_clear_acc(mlu_clear_acc), .mlu_clear_sort(mlu_clear_sort),
        .mlu_index(mlu_index), .mlu_fun_id(mlu_fun_id), .mlu_asce(mlu_asce),
        .mlu_sel_output(mlu_sel_output), .mlu_out_scalar(mlu_out_scalar), .mlu_out_ksort(mlu_out_ksort),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ksort(res_ksort),
        .res_last(res_last),
`ifdef MLU_SEQ_PERF_EN
        .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
        .busy(busy)
    );

    // Products for DOT/NONLIN, squared differences for DIST/KNN, summed over the 16 lanes.
    function automatic logic [31:0] lane_sum(input logic [16*DW-1:0] h, input logic [16*DW-1:0] c,
                                             input logic sub);
        logic [31:0] s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        s = 32'd0;
        for (int i = 0; i < 16; i++) begin
            a = h[i*DW +: DW];
            b = c[i*DW +: DW];
            t = a - b;
            s = s + (sub ? t * t : a * b);
        end
        return s;
    endfunction

    function automatic logic [16*DW-1:0] make_chunk(input int maxv);
        logic [16*DW-1:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i*DW +: DW] = DW'($urandom_range(0, maxv));
        end
        return v;
    endfunction

    // Behavioural MLU: accumulator cleared by clear_acc, result list shifted on is_output.
    logic [31:0]      m_acc = 32'd0;
    logic [KK*32-1:0] m_ks = '0;
    always @(posedge clk) begin
        if (mlu_clear_acc) begin
            m_acc <= 32'd0;
        end else begin
            m_acc <= m_acc + lane_sum(mlu_hot, mlu_cold, mlu_sel_in);
        end
        if (mlu_clear_sort) begin
            m_ks <= '0;
        end else if (mlu_is_output) begin
            m_ks <= {m_ks[(KK-1)*32-1:0], mlu_index[15:0], m_acc[15:0]};
        end
    end
    assign mlu_out_scalar = m_acc;
    assign mlu_out_ksort  = m_ks;

    // Event monitor on the falling edge; tasks read these only just after a rising edge.
    int         n_clr_acc = 0;
    int         n_clr_sort = 0;
    int         n_beats = 0;
    int         n_res_rise = 0;
    int         n_gate_err = 0;
    logic       prev_rv = 1'b0;
    logic [2:0] last_sel = 3'd0;
    int         idx_q[$];
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mlu_clear_acc)  n_clr_acc++;
            if (mlu_clear_sort) n_clr_sort++;
            if (mlu_is_output) begin
                last_sel = mlu_sel_output;
                idx_q.push_back(int'(mlu_index));
            end
            if (in_valid && in_ready) begin
                n_beats++;
                if (mlu_hot !== in_hot || mlu_cold !== in_cold) n_gate_err++;
            end else if (mlu_hot !== '0 || mlu_cold !== '0) begin
                n_gate_err++;
            end
            if (res_valid && !prev_rv) n_res_rise++;
            prev_rv = res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int len, input int nvec,
                            input logic [2:0] fid, input logic asc);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_wait: cmd_ready=%0b, required 1", cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_len    = LW'(len);
        cmd_nvec   = LW'(nvec);
        cmd_fun_id = fid;
        cmd_asce   = asc;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic put_beat(input logic [16*DW-1:0] h, input logic [16*DW-1:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_hot   = h;
        in_cold  = c;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_wait: in_ready=%0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_hot   = make_chunk(1000);
        in_cold  = make_chunk(1000);
    endtask

    task automatic get_result(input int delay, output logic [31:0] d, output logic last,
                              output logic [KK*32-1:0] ks, output logic [2:0] sel);
        int n;
        n = 0;
        d = 32'd0; last = 1'b0; ks = '0; sel = 3'd0;
        while (res_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL res_wait: res_valid=%0b, required 1", res_valid);
            return;
        end
        repeat (delay) tick();
        d    = res_data;
        last = res_last;
        ks   = res_ksort;
        sel  = mlu_sel_output;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, busy, in_ready, res_valid, res_last} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_hs: got rdy/busy/in_rdy/rv/last=%b, want 10000",
                     {cmd_ready, busy, in_ready, res_valid, res_last});
        end
        checks++;
        if ({mlu_clear_acc, mlu_clear_sort, mlu_is_output, mlu_sel_output, mlu_symbol, mlu_sel_in} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b, want all zero",
                     {mlu_clear_acc, mlu_clear_sort, mlu_is_output, mlu_sel_output, mlu_symbol, mlu_sel_in});
        end
        checks++;
        if (mlu_index !== '0 || res_data !== 32'd0 || mlu_hot !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: index=%0d res_data=%0h, want 0", mlu_index, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dot();
        logic [16*DW-1:0] h;
        logic [16*DW-1:0] c;
        int ca0;
        for (int i = 0; i < 16; i++) begin
            h[i*DW +: DW] = 32'd1;
            c[i*DW +: DW] = 32'd2;
        end
        ca0 = n_clr_acc;
        send_cmd(OP_DOT, 2, 1, 3'd0, 1'b0);
        put_beat(h, c);
        put_beat(h, c);
        checks++;
        if (mlu_is_output !== 1'b1 || mlu_sel_output !== SEL_ACC || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dot_out: is_out=%0b sel=%0d in_rdy=%0b rv=%0b, want 1 2 0 0",
                     mlu_is_output, mlu_sel_output, in_ready, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_last !== 1'b1 || mlu_is_output !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dot_latency: rv=%0b last=%0b is_out=%0b, want 1 1 0",
                     res_valid, res_last, mlu_is_output);
        end
        checks++;
        if (res_data !== 32'd64) begin
            errors++;
            $display("[TB] FAIL dot_data: got %0d, want 64", res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || (n_clr_acc - ca0) != 1) begin
            errors++;
            $display("[TB] FAIL dot_done: busy=%0b cmd_rdy=%0b clears=%0d, want 0 1 1",
                     busy, cmd_ready, n_clr_acc - ca0);
        end
    endtask

    task automatic test_dist();
        logic [16*DW-1:0] h;
        logic [16*DW-1:0] c;
        logic [31:0]      exp_d;
        logic [31:0]      d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        int               g0;
        g0 = n_gate_err;
        send_cmd(OP_DIST, 1, 3, 3'd0, 1'b0);
        for (int v = 0; v < 3; v++) begin
            repeat ($urandom_range(1, 3)) tick();
            h = make_chunk(255);
            c = make_chunk(255);
            exp_d = lane_sum(h, c, 1'b1);
            put_beat(h, c);
            get_result($urandom_range(0, 2), d, last, ks, sel);
            checks++;
            if (d !== exp_d || last !== (v == 2)) begin
                errors++;
                $display("[TB] FAIL dist_res%0d: got %0d last=%0b, want %0d last=%0b",
                         v, d, last, exp_d, (v == 2));
            end
            checks++;
            if (mlu_symbol !== SYM_SUB || mlu_sel_in !== 1'b1) begin
                errors++;
                $display("[TB] FAIL dist_ctl%0d: symbol=%b sel_in=%0b, want 10 1", v, mlu_symbol, mlu_sel_in);
            end
        end
        checks++;
        if (n_gate_err != g0) begin
            errors++;
            $display("[TB] FAIL dist_gate: %0d ungated lane cycles, want 0", n_gate_err - g0);
        end
    endtask

    task automatic test_knn();
        logic [16*DW-1:0] h;
        logic [16*DW-1:0] c;
        logic [31:0]      kd [0:24];
        logic [KK*32-1:0] exp_ks;
        logic [31:0]      d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        int ca0, cs0, rr0, q0;
        logic idx_ok;
        ca0 = n_clr_acc; cs0 = n_clr_sort; rr0 = n_res_rise; q0 = idx_q.size();
        send_cmd(OP_KNN, 1, 25, 3'd0, 1'b1);
        for (int v = 0; v < 25; v++) begin
            h = make_chunk(15);
            c = make_chunk(15);
            kd[v] = lane_sum(h, c, 1'b1);
            put_beat(h, c);
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int j = 0; j < KK; j++) begin
            exp_ks[j*32 +: 32] = {16'(24 - j), kd[24 - j][15:0]};
        end
        get_result(2, d, last, ks, sel);
        checks++;
        if (last !== 1'b1 || sel !== SEL_KSORT || mlu_asce !== 1'b1) begin
            errors++;
            $display("[TB] FAIL knn_kout: last=%0b sel=%0d asce=%0b, want 1 5 1", last, sel, mlu_asce);
        end
        checks++;
        if (ks !== exp_ks) begin
            errors++;
            $display("[TB] FAIL knn_list: slot0=%0h slot19=%0h, want %0h %0h",
                     ks[31:0], ks[KK*32-1 -: 32], exp_ks[31:0], exp_ks[KK*32-1 -: 32]);
        end
        checks++;
        if ((n_res_rise - rr0) != 1 || (n_clr_sort - cs0) != 1 || (n_clr_acc - ca0) != 25) begin
            errors++;
            $display("[TB] FAIL knn_counts: results=%0d clr_sort=%0d clr_acc=%0d, want 1 1 25",
                     n_res_rise - rr0, n_clr_sort - cs0, n_clr_acc - ca0);
        end
        idx_ok = (idx_q.size() - q0) == 25;
        for (int v = 0; v < 25 && idx_ok; v++) begin
            if (idx_q[q0 + v] != v) idx_ok = 1'b0;
        end
        checks++;
        if (!idx_ok) begin
            errors++;
            $display("[TB] FAIL knn_index: %0d outputs seen, want index sequence 0..24", idx_q.size() - q0);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [16*DW-1:0] h0, c0, h1, c1;
        logic [31:0]      e0, e1, d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        int n, b0;
        h0 = make_chunk(255); c0 = make_chunk(255);
        h1 = make_chunk(255); c1 = make_chunk(255);
        e0 = lane_sum(h0, c0, 1'b0);
        e1 = lane_sum(h1, c1, 1'b0);
        send_cmd(OP_DOT, 1, 2, 3'd0, 1'b0);
        put_beat(h0, c0);
        in_valid = 1'b1; in_hot = h1; in_cold = c1;
        n = 0;
        while (res_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        b0 = n_beats;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== e0 || res_last !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall%0d: rv=%0b data=%0d last=%0b in_rdy=%0b, want 1 %0d 0 0",
                         s, res_valid, res_data, res_last, in_ready, e0);
            end
            tick();
        end
        checks++;
        if (n_beats != b0) begin
            errors++;
            $display("[TB] FAIL stall_beats: %0d beats taken during stall, want 0", n_beats - b0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        put_beat(h1, c1);
        get_result(0, d, last, ks, sel);
        checks++;
        if (d !== e1 || last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_next: got %0d last=%0b, want %0d last=1", d, last, e1);
        end
    endtask

    task automatic test_reset_mid();
        logic [16*DW-1:0] h, c;
        logic [31:0]      e, d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        send_cmd(OP_DOT, 3, 1, 3'd0, 1'b0);
        put_beat(make_chunk(255), make_chunk(255));
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_hs: busy=%0b cmd_rdy=%0b in_rdy=%0b rv=%0b, want 0 1 0 0",
                     busy, cmd_ready, in_ready, res_valid);
        end
        checks++;
        if ({mlu_clear_acc, mlu_clear_sort, mlu_is_output} !== 3'b000 || mlu_hot !== '0) begin
            errors++;
            $display("[TB] FAIL abort_pulses: got %b, want 000 with zero lanes",
                     {mlu_clear_acc, mlu_clear_sort, mlu_is_output});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        h = make_chunk(255); c = make_chunk(255);
        e = lane_sum(h, c, 1'b0);
        send_cmd(OP_DOT, 2, 1, 3'd0, 1'b0);
        put_beat(h, c);
        put_beat(c, h);
        get_result(1, d, last, ks, sel);
        checks++;
        if (d !== (e + e) || last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_rerun: got %0d last=%0b, want %0d last=1", d, last, e + e);
        end
    endtask

    task automatic test_len_zero();
        logic [16*DW-1:0] h, c;
        logic [31:0]      e, d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        int b0, r0;
        h = make_chunk(255); c = make_chunk(255);
        e = lane_sum(h, c, 1'b0);
        b0 = n_beats; r0 = n_res_rise;
        send_cmd(OP_DOT, 0, 0, 3'd0, 1'b0);
        put_beat(h, c);
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || mlu_is_output !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len0_out: in_rdy=%0b is_out=%0b, want 0 1", in_ready, mlu_is_output);
        end
        get_result(0, d, last, ks, sel);
        in_valid = 1'b0;
        checks++;
        if (d !== e || last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len0_res: got %0d last=%0b, want %0d last=1", d, last, e);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || (n_beats - b0) != 1 || (n_res_rise - r0) != 1) begin
            errors++;
            $display("[TB] FAIL len0_count: busy=%0b beats=%0d results=%0d, want 0 1 1",
                     busy, n_beats - b0, n_res_rise - r0);
        end
    endtask

    task automatic test_random();
        logic [16*DW-1:0] h, c;
        logic [31:0]      e, d;
        logic             last;
        logic [KK*32-1:0] ks;
        logic [2:0]       sel;
        logic [1:0]       op;
        logic [2:0]       fid;
        int len, nvec;
        for (int t = 0; t < 6; t++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_DOT;
                1:       op = OP_DIST;
                default: op = OP_NONLIN;
            endcase
            len  = $urandom_range(1, 3);
            nvec = $urandom_range(1, 3);
            fid  = 3'($urandom_range(0, 7));
            send_cmd(op, len, nvec, fid, 1'b0);
            for (int v = 0; v < nvec; v++) begin
                e = 32'd0;
                for (int b = 0; b < len; b++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    h = make_chunk(255); c = make_chunk(255);
                    e = e + lane_sum(h, c, op == OP_DIST);
                    put_beat(h, c);
                end
                get_result($urandom_range(0, 3), d, last, ks, sel);
                checks++;
                if (d !== e || last !== (v == nvec - 1)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_v%0d: got %0d last=%0b, want %0d last=%0b",
                             t, v, d, last, e, (v == nvec - 1));
                end
                checks++;
                if (last_sel !== ((op == OP_NONLIN) ? SEL_NONLIN : SEL_ACC) || mlu_fun_id !== fid) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_sel: sel=%0d fun_id=%0d, want %0d %0d", t, last_sel,
                             mlu_fun_id, (op == OP_NONLIN) ? SEL_NONLIN : SEL_ACC, fid);
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_dot();
        test_dist();
        test_knn();
        test_back_to_back_stall();
        test_reset_mid();
        test_len_zero();
        test_random();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mlu_seq.md
Name: mlu_seq

Overview:
- Sequencer in front of the MLU datapath: accepts one command, streams operand chunks (16 lanes) into the MLU, and pulses acc clear/output, ksort clear/index and the sel/symbol/fun_id controls.
- Returns one scalar result per vector, or the K-sorted list for k-NN.
- Sits between the buffer/DMA stream and the MLU; owns the MLU operand path, zero-gating lanes on idle cycles so the accumulator adds 0.

Parameters:
- DATA_WIDTH, 32, lane width.
- LEN_WIDTH, 16, width of chunk-count and vector-count fields.
- K, 20, ksort depth; must match the MLU.
- INDEX_WIDTH, 32, width of mlu_index.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid/cmd_ready  in/out  1  command handshake; ready only in IDLE.
- cmd_op  in  2  0=DOT, 1=DIST, 2=KNN, 3=NONLIN.
- cmd_len  in  LEN_WIDTH  chunks per vector (0 treated as 1).
- cmd_nvec  in  LEN_WIDTH  vectors per command (0 treated as 1).
- cmd_fun_id  in  3  nonlinear function id (NONLIN).
- cmd_asce  in  1  sort order (KNN).
- in_valid/in_ready  in/out  1  operand beat handshake.
- in_hot, in_cold  in  16xDATA_WIDTH  operand chunk.
- mlu_hot, mlu_cold  out  16xDATA_WIDTH  operands to MLU; in_* on a beat, else all-zero.
- mlu_symbol  out  2  2'b10 for DIST/KNN, else 2'b00.
- mlu_sel_in  out  1  1 for DIST/KNN (square adder output), else 0.
- mlu_is_output, mlu_clear_acc, mlu_clear_sort  out  1  one-cycle pulses.
- mlu_index  out  INDEX_WIDTH  current vector number.
- mlu_fun_id, mlu_asce  out  3/1  latched from command.
- mlu_sel_output  out  3  MLU output select (2=acc, 4=nonlin, 5=ksort).
- mlu_out_scalar  in  32; mlu_out_ksort  in  Kx32  MLU results.
- res_valid/res_ready  out/in  1  result handshake.
- res_data  out  32  scalar result.
- res_ksort  out  Kx32  sorted list, valid with res_last in KNN.
- res_last  out  1  marks final result of command.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; counters and latched fields cleared.
- Command accepted on cmd_valid&cmd_ready. Fields are latched; cmd_ready drops the next cycle.
- States:
  - IDLE -> CLR on accept.
  - CLR (1 cycle): mlu_clear_acc=1; also mlu_clear_sort=1 if KNN.
  - STREAM: in_ready=1; each in_valid&in_ready is a beat; the chunk counter increments; after beat cmd_len-1 -> OUT.
  - OUT (1 cycle): mlu_is_output=1; mlu_sel_output = 4 if NONLIN, else 2.
  - RES: res_valid held until res_ready. KNN skips RES (ksort consumes mlu_index). Vector counter increments; if not last -> CLR2 (acc clear only) -> STREAM.
  - After the last vector: KNN -> KOUT (sel_output=5, res_valid, res_last=1); others -> IDLE after final handshake.
- Latency: res_valid asserts exactly 2 cycles after the last beat of a vector (OUT, then RES). in_ready is low in CLR/OUT/RES.
- Non-beat cycles drive mlu_hot/mlu_cold to 0. Lanes are never passed through without a handshake.
- res_data and res_ksort are held stable while res_valid&!res_ready.
- Counters are LEN_WIDTH wide, compared with equality to len-1; no wrap within a command.
- rst_n low mid-command aborts immediately to IDLE. No result is emitted, and the MLU is cleared by the next CLR.
- cmd_valid while busy is ignored (no queueing).
- mlu_index equals the vector counter, zero-extended.

Optional Feature:
- MLU_SEQ_PERF_EN defined: adds outputs perf_busy_cycles (32) and perf_stall_cycles (32). They count busy cycles, and STREAM cycles with in_valid=0 or RES cycles with res_ready=0. Both saturate at all-ones and clear on command accept.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mlu_pkg: op enum (OP_DOT, OP_DIST, OP_KNN, OP_NONLIN); state enum; LANES=16; SEL_ACC=2, SEL_NONLIN=4, SEL_KSORT=5; SYM_SUB=2'b10.
- One sub-module mlu_loop_cnt (counter with load, inc, last flag), instantiated for chunks and vectors.

Test Plan:
- DOT, len=2, nvec=1: hot=1, cold=2 lanes over 2 beats -> one clear pulse, is_output 1 cycle after beat 2, res_data=64, res_last=1.
- DIST, len=1, nvec=3 with in_valid gaps: mlu_hot is zero on gap cycles; 3 results with the correct squared distances; symbol=2'b10, sel_in=1 throughout.
- KNN, nvec=25, K=20: clear_sort only once; mlu_index 0..24; single KOUT result, res_last=1, sel_output=5, no intermediate res_valid.
- Backpressure: res_ready low 5 cycles -> res_data stable, in_ready=0, no new beat accepted.
- Reset mid-STREAM (beat 1 of 3) -> busy=0, cmd_ready=1 and all pulses 0 immediately; the next command runs correctly from CLR.
- len=0, nvec=0 -> treated as 1/1: exactly one beat, one result.
